nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that computes A + B + ci over 4*NIBBLES bits using a single 4-bit adder slice, one nibble per clock, LSB nibble first.
- The carry is registered between nibbles.
- Sits directly upstream of the 4-bit full-adder stage: it sequences operand nibbles into the slice and collects each nibble's s/co into the wide result.
- Trades latency for area where a full-width adder is not wanted.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed per operation; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only when not busy
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- ci  input  1  carry-in, captured on accepted start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse: s/co hold a fresh result
- s  output  W  sum result, held until next completion
- co  output  1  carry-out of MSB nibble, held until next completion

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). When rst=1 at a rising edge, the following are all cleared: state→IDLE, busy=0, done=0, s=0, co=0, nibble index=0, internal operand/partial/carry registers=0. rst has priority over start.
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: capture a, b and ci into internal registers; clear the partial-sum register; set index=0; go to RUN.
- RUN:
  - busy=1, done=0.
  - Each cycle, the slice adds nibble[index] of A, nibble[index] of B and the carry register.
  - The 4-bit sum is written into partial-sum bits [4*index+3:4*index]; the slice co is written to the carry register; index increments.
  - After the cycle with index = NIBBLES-1: load s ← partial sum (including the final nibble) and co ← final carry, then go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - If start=1 in this cycle: accept the new operation (capture operands, go to RUN). Otherwise go to IDLE.
- Latency: start sampled at edge T → busy high for cycles T+1..T+NIBBLES → done high in cycle T+NIBBLES+1, with s/co valid from that cycle onward.
- Throughput: one operation per NIBBLES+1 cycles when start is held high.
- start while busy=1 is ignored: not queued, and the in-flight operation is unaffected.
- Changes on a/b/ci after capture have no effect on the in-flight operation.
- s and co change only on completion (or reset). They remain stable through IDLE and through the RUN phase of the next operation.
- Arithmetic:
  - {co, s} = a + b + ci, exact modulo 2^(W+1).
  - The carry chain is bit-exact with a W-bit ripple adder.
  - No overflow or sign interpretation is applied.
- Reset during RUN aborts the operation: no done pulse; s/co read 0; the block is ready for start on the next cycle.
- NIBBLES=1: one RUN cycle, done at T+2.
- The index counter width is ceil(log2(NIBBLES)) bits, minimum 1. The index never exceeds NIBBLES-1.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h4321, ci=0, start pulse at edge T → busy high T+1..T+4, done=1 only in T+5, s=16'h5555, co=0.
- a=16'hFFFF, b=16'h0001, ci=0 → carry ripples through all four nibbles: s=16'h0000, co=1. Then a=16'hFFFF, b=16'hFFFF, ci=1 → s=16'hFFFF, co=1.
- Start accepted with a=16'h00F0, b=16'h0010, ci=0; at T+2 assert start with a=16'hAAAA, b=16'h5555 → second start ignored, done once at T+5 with s=16'h0100, co=0; busy never drops early.
- Reset mid-operation: start a=16'h8000, b=16'h8000, assert rst at T+2 → from T+3: busy=0, done=0, s=0, co=0, no done pulse. Fresh start a=16'h0003, b=16'h0004, ci=1 → s=16'h0008, co=0 after 5 cycles.
- Back-to-back: start held high continuously with new operands each done cycle → completions every 5 cycles. Each s/co matches its captured operands, and s/co remain unchanged between done pulses.
- Random regression: 1000 operations with {ci,a,b} = $random, compared against the {co,s} = a+b+ci reference model at each done. Repeat with NIBBLES=1 (done at T+2) and NIBBLES=8.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder built from one 4-bit slice, one nibble per
// clock, LSB nibble first. Carry is registered between nibbles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a new addition (accepted in IDLE or DONE)
//   a, b, ci   operands and carry-in, captured on an accepted start
//   busy       high while nibbles are being processed
//   done       one-cycle pulse: s/co hold a fresh result
//   s, co      W-bit sum and carry-out, held until the next completion

// 4-bit adder slice shared by every nibble of the operation.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q, b_q;   // shifted right one nibble per RUN cycle
  logic            cy;
  logic [W-1:0]    part, part_nxt;
  logic [3:0]      sum;
  logic            sco;
  logic            last;
  logic            accept;

  assign last   = (idx == IW'(NIBBLES - 1));
  assign accept = start && (state == IDLE || state == DONE);

  // The operand registers shift so the current nibble is always at [3:0].
  nibble_add4 u_slice (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (cy),
    .s  (sum),
    .co (sco)
  );

  // Partial sum with the current nibble's result merged in at idx.
  always_comb begin
    part_nxt = part;
    for (int i = 0; i < NIBBLES; i++)
      if (idx == IW'(i)) part_nxt[4*i +: 4] = sum;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = start ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      cy   <= 1'b0;
      part <= '0;
      idx  <= '0;
      s    <= '0;
      co   <= 1'b0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      cy   <= ci;
      part <= '0;
      idx  <= '0;
    end else if (state == RUN) begin
      a_q  <= a_q >> 4;
      b_q  <= b_q >> 4;
      cy   <= sco;
      part <= part_nxt;
      if (last) begin
        s   <= part_nxt;
        co  <= sco;
        idx <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end
endmodule
